// File: rtl/exec_pkg.sv
// Shared definitions for the MIPS execute stage: datapath width, ALU op codes
// and the multiply/divide FSM state encoding.
package exec_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 5;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  // 18 operations do not fit in 4 bits, so the op field is 5 bits wide.
  localparam alu_op_t ALU_ADD   = 5'd0;
  localparam alu_op_t ALU_SUB   = 5'd1;
  localparam alu_op_t ALU_AND   = 5'd2;
  localparam alu_op_t ALU_OR    = 5'd3;
  localparam alu_op_t ALU_XOR   = 5'd4;
  localparam alu_op_t ALU_NOR   = 5'd5;
  localparam alu_op_t ALU_SLT   = 5'd6;
  localparam alu_op_t ALU_SLTU  = 5'd7;
  localparam alu_op_t ALU_SLL   = 5'd8;
  localparam alu_op_t ALU_SRL   = 5'd9;
  localparam alu_op_t ALU_SRA   = 5'd10;
  localparam alu_op_t ALU_LUI   = 5'd11;
  localparam alu_op_t ALU_MFHI  = 5'd12;
  localparam alu_op_t ALU_MFLO  = 5'd13;
  localparam alu_op_t ALU_MULT  = 5'd14;
  localparam alu_op_t ALU_MULTU = 5'd15;
  localparam alu_op_t ALU_DIV   = 5'd16;
  localparam alu_op_t ALU_DIVU  = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input alu_op_t op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E-stage inputs and M-stage outputs of the execute stage, bundled as one bus.
// master = decode/hazard side driving E, slave = the execute stage itself.
interface execute_stage_if;
  import exec_pkg::*;

  logic            ValidE;
  logic            RegWriteE;
  logic            MemToRegE;
  logic            MemWriteE;
  alu_op_t         AluControlE;
  logic            AluSrcE;
  logic            RegDstE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] RegDataBE;
  logic [XLEN-1:0] SignImmE;
  logic [4:0]      RtE;
  logic [4:0]      RdE;
  logic            FlushE;
  logic            StallE;
  logic            RegWriteM;
  logic            MemToRegM;
  logic            MemWriteM;
  logic [XLEN-1:0] AluOutM;
  logic [XLEN-1:0] WriteDataM;
  logic [4:0]      WriteRegM;
  logic            ValidM;

  modport master (
    output ValidE, RegWriteE, MemToRegE, MemWriteE, AluControlE, AluSrcE, RegDstE,
           SrcAE, RegDataBE, SignImmE, RtE, RdE, FlushE,
    input  StallE, RegWriteM, MemToRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM, ValidM
  );

  modport slave (
    input  ValidE, RegWriteE, MemToRegE, MemWriteE, AluControlE, AluSrcE, RegDstE,
           SrcAE, RegDataBE, SignImmE, RtE, RdE, FlushE,
    output StallE, RegWriteM, MemToRegM, MemWriteM, AluOutM, WriteDataM, WriteRegM, ValidM
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiplier and restoring
// divider on magnitudes, sign-corrected on completion. Divider only with EXEC_DIV_EN.
module mul_div_unit
  import exec_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(MD_ITERS);

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] w_q, w_d;        // multiply: {acc, multiplier}; divide: {rem, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic              neg_q, neg_d;    // negate product / quotient at the end
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              op_ok, op_signed, go;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod;

  assign mul_sum  = {1'b0, w_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = w_q[0] ? {mul_sum, w_q[XLEN-1:1]} : {1'b0, w_q[2*XLEN-1:1]};
  assign prod     = neg_q ? -w_q : w_q;

`ifdef EXEC_DIV_EN
  logic              op_div;
  logic              div_q, div_d;
  logic              rneg_q, rneg_d;  // remainder takes the dividend's sign
  logic              dvz_q, dvz_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem;

  assign op_ok     = is_md_op(op_i);
  assign op_signed = (op_i == ALU_MULT) || (op_i == ALU_DIV);
  assign op_div    = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
  assign div_diff  = w_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {w_q[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], w_q[XLEN-2:0], 1'b1};
  assign quo       = neg_q  ? -w_q[XLEN-1:0]      : w_q[XLEN-1:0];
  assign rem       = rneg_q ? -w_q[2*XLEN-1:XLEN] : w_q[2*XLEN-1:XLEN];
`else
  assign op_ok     = (op_i == ALU_MULT) || (op_i == ALU_MULTU);
  assign op_signed = (op_i == ALU_MULT);
`endif

  assign go     = start_i && op_ok && (state_q == MD_IDLE);
  assign busy_o = go || (state_q == MD_BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef EXEC_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dvz_d   = dvz_q;
    dvd_d   = dvd_q;
`endif
    case (state_q)
      MD_IDLE: begin
        if (go) begin
          state_d = MD_BUSY;
          cnt_d   = '0;
          neg_d   = op_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
          w_d     = {{XLEN{1'b0}}, magnitude(b_i, op_signed)};
          opnd_d  = magnitude(a_i, op_signed);
`ifdef EXEC_DIV_EN
          div_d   = op_div;
          rneg_d  = op_signed && a_i[XLEN-1];
          dvz_d   = (b_i == '0);
          dvd_d   = a_i;
          if (op_div) begin
            w_d    = {{XLEN{1'b0}}, magnitude(a_i, op_signed)};
            opnd_d = magnitude(b_i, op_signed);
          end
`endif
        end
      end
      MD_BUSY: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else begin
`ifdef EXEC_DIV_EN
          w_d = div_q ? div_next : mul_next;
`else
          w_d = mul_next;
`endif
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MD_ITERS - 1)) state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!abort_i) begin
          {hi_d, lo_d} = prod;
`ifdef EXEC_DIV_EN
          if (div_q) begin
            lo_d = dvz_q ? {XLEN{1'b1}} : quo;
            hi_d = dvz_q ? dvd_q : rem;
          end
`endif
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef EXEC_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dvz_q   <= 1'b0;
      dvd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef EXEC_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dvz_q   <= dvz_d;
      dvd_q   <= dvd_d;
`endif
    end
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage and EX/MEM register: operand mux, single-cycle ALU, destination mux,
// and the iterative mul/div unit that stalls the front end (divide needs EXEC_DIV_EN).
module execute_stage
  import exec_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic           clk,
  input  logic           reset,
  execute_stage_if.slave ex
);

  logic        [XLEN-1:0] srca, srcb, alu_res, md_hi, md_lo;
  logic signed [XLEN-1:0] srca_s, srcb_s;
  logic        [4:0]      shamt, dest;
  logic                   md_op, md_start, md_busy, take;

  logic            valid_q, valid_d, regwrite_q, regwrite_d;
  logic            memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;
  logic [XLEN-1:0] aluout_q, aluout_d, wdata_q, wdata_d;
  logic [4:0]      wreg_q, wreg_d;

  assign srca   = ex.SrcAE;
  assign srcb   = ex.AluSrcE ? ex.SignImmE : ex.RegDataBE;
  assign srca_s = srca;
  assign srcb_s = srcb;
  assign shamt  = srcb[4:0];
  assign dest   = ex.RegDstE ? ex.RdE : ex.RtE;

  always_comb begin
    alu_res = '0;
    case (ex.AluControlE)
      ALU_ADD:  alu_res = srca + srcb;
      ALU_SUB:  alu_res = srca - srcb;
      ALU_AND:  alu_res = srca & srcb;
      ALU_OR:   alu_res = srca | srcb;
      ALU_XOR:  alu_res = srca ^ srcb;
      ALU_NOR:  alu_res = ~(srca | srcb);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, (srca_s < srcb_s)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  alu_res = srca << shamt;
      ALU_SRL:  alu_res = srca >> shamt;
      ALU_SRA:  alu_res = srca_s >>> shamt;
      ALU_LUI:  alu_res = srcb << 16;
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_res = '0;
    endcase
  end

  assign md_op    = is_md_op(ex.AluControlE);
  assign md_start = ex.ValidE && !ex.FlushE && md_op;

  mul_div_unit #(
    .MD_ITERS(MD_ITERS)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start_i(md_start),
    .op_i   (ex.AluControlE),
    .a_i    (srca),
    .b_i    (ex.RegDataBE),
    .abort_i(ex.FlushE),
    .busy_o (md_busy),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  assign ex.StallE = md_busy;
  assign take      = !md_busy && ex.ValidE && !ex.FlushE;

  // ---- EX/MEM boundary: anything not taken becomes an all-zero bubble ----
  always_comb begin
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    aluout_d   = '0;
    wdata_d    = '0;
    wreg_d     = '0;
    if (take) begin
      valid_d    = 1'b1;
      regwrite_d = ex.RegWriteE && !md_op;  // HI/LO writers never touch the register file
      memtoreg_d = ex.MemToRegE;
      memwrite_d = ex.MemWriteE;
      aluout_d   = alu_res;
      wdata_d    = ex.RegDataBE;
      wreg_d     = dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      aluout_q   <= '0;
      wdata_q    <= '0;
      wreg_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      aluout_q   <= aluout_d;
      wdata_q    <= wdata_d;
      wreg_q     <= wreg_d;
    end
  end

  assign ex.ValidM     = valid_q;
  assign ex.RegWriteM  = regwrite_q;
  assign ex.MemToRegM  = memtoreg_q;
  assign ex.MemWriteM  = memwrite_q;
  assign ex.AluOutM    = aluout_q;
  assign ex.WriteDataM = wdata_q;
  assign ex.WriteRegM  = wreg_q;

endmodule
